truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential, self-checking exhaustive stimulus engine for an N-input, 1-output combinational block under test.
- After a start request it drives every input vector 0 .. 2**N_IN-1 in ascending order and holds each one for a programmable number of clock cycles.
- On the last hold cycle of each vector it samples the block's output and compares it against a parametrised expected truth table.
- It reports the mismatch count, the first failing vector, and pass/done status. It is the parametrised, in-fabric successor to hand-written exhaustive lab benches.

Parameters:
- N_IN, 4, number of inputs of the block under test (1..8).
- HOLD_CYCLES, 20, clock cycles each vector stays on stim; minimum 1.
- EXP_TABLE, 16'h6996, expected output truth table, width 2**N_IN, LSB-aligned. Bit k is the expected output for vector k.
- STOP_ON_FAIL, 0, when 1 the sweep ends at the first mismatch.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  sweep request. Sampled in IDLE or DONE only.
- dut_f  input  1  output of the block under test.
- stim  output  N_IN  input vector driven to the block under test.
- busy  output  1  high while a sweep is running.
- done  output  1  high (level) from sweep end until the next start or reset.
- pass  output  1  valid while done is high; 1 when err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors.
- first_fail_valid  output  1  set at the first mismatch.
- first_fail_vec  output  N_IN  index of the first mismatching vector.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0. FSM=IDLE, hold counter=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE -> APPLY when start=1 at the edge. In the following cycle: busy=1, stim=0, hold counter=0. err_count, first_fail_valid, first_fail_vec, done and pass are all cleared.
- APPLY:
  - The hold counter counts 0 .. HOLD_CYCLES-1. stim stays constant for exactly HOLD_CYCLES cycles.
  - At the edge where the hold counter equals HOLD_CYCLES-1, dut_f is compared with EXP_TABLE[stim].
  - On mismatch: err_count increments. If first_fail_valid=0, first_fail_vec<=stim and first_fail_valid<=1.
- Vector advance:
  - If stim != 2**N_IN-1 and there is no STOP_ON_FAIL termination: stim increments and the hold counter returns to 0.
  - Otherwise -> DONE: busy=0, done=1, pass=(final err_count==0), stim returns to 0.
- Sweep length: a full sweep keeps busy high for exactly 2**N_IN*HOLD_CYCLES cycles.
- STOP_ON_FAIL=1: a mismatch on vector k ends the sweep after that compare, so busy lasts (k+1)*HOLD_CYCLES cycles and err_count=1.
- DONE: result outputs hold. start=1 behaves as in IDLE (done clears next cycle, new sweep begins).
- start while busy: ignored, including start held high throughout. No restart and no effect on counters.
- Reset mid-sweep: at the rst edge all outputs go to reset values and the FSM returns to IDLE. No partial results are retained.
- rst and start high together: rst wins.
- err_count width N_IN+1 holds the maximum 2**N_IN without overflow. No saturation logic is required.
- HOLD_CYCLES=1: one vector per cycle, a compare on every cycle.
- stim is registered. The block under test is combinational, so dut_f is settled by the compare edge whenever HOLD_CYCLES>=1.

Test Plan:
1. Reset: assert rst for 3 cycles with random start/dut_f -> all outputs 0, FSM IDLE, stim=0.
2. Full pass, N_IN=4, HOLD_CYCLES=20: dut_f = XOR of stim bits, one-cycle start pulse -> busy high 320 cycles, stim steps 0..15 every 20 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
3. Faulty block: same model with dut_f inverted for vectors 5 and 11 -> done=1, pass=0, err_count=2, first_fail_valid=1, first_fail_vec=5.
4. STOP_ON_FAIL=1 with the step 3 fault -> busy high 120 cycles, done=1, err_count=1, first_fail_vec=5, stim=0 after termination.
5. Reset mid-sweep while stim=7 -> next cycle all outputs 0. A fresh start pulse runs a clean full sweep with results as in step 2.
6. Start handling:
   - Start held high for the whole sweep -> exactly one sweep, done=1.
   - Start pulse in DONE after the step 3 run, with a correct block -> done clears, err_count clears, new sweep ends with pass=1.
   - Rerun step 2 with N_IN=3, HOLD_CYCLES=1, EXP_TABLE=8'h96 -> busy 8 cycles, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector of an N_IN-input block,
// holds each for HOLD_CYCLES clocks and checks the output against EXP_TABLE.
module truth_table_sweeper #(
    parameter int unsigned              N_IN         = 4,
    parameter int unsigned              HOLD_CYCLES  = 20,
    parameter logic [(2**N_IN)-1:0]     EXP_TABLE    = 16'h6996,
    parameter bit                       STOP_ON_FAIL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_f,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int unsigned     HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned     EW        = N_IN + 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN:0]   err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            mismatch;
    logic            stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        hold_d   = hold_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        done_d   = done_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        stop     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    stim_d  = '0;
                    hold_d  = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    // Compare only on the final hold cycle so dut_f has settled.
                    mismatch = (dut_f != EXP_TABLE[stim_q]);
                    stop     = STOP_ON_FAIL && mismatch;
                    err_d    = err_q + EW'(mismatch);
                    if (mismatch && !ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = stim_q;
                    end
                    hold_d = '0;
                    if ((stim_q != STIM_LAST) && !stop) begin
                        stim_d = stim_q + N_IN'(1);
                    end else begin
                        state_d = S_DONE;
                        stim_d  = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stim             = stim_q;
    assign busy             = (state_q == S_APPLY);
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three parameterisations sharing clk/rst,
// each fed by a parity model with optional injected faults on vectors 5 and 11.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, start_c;
    logic fault, rand_mode, rand_f;
    logic f_a, f_b, f_c;

    logic [3:0] a_stim, a_ffvec, b_stim, b_ffvec;
    logic [2:0] c_stim, c_ffvec;
    logic [4:0] a_err, b_err;
    logic [3:0] c_err;
    logic a_busy, a_done, a_pass, a_ffv;
    logic b_busy, b_done, b_pass, b_ffv;
    logic c_busy, c_done, c_pass, c_ffv;

    int checks = 0;
    int failures = 0;
    logic [31:0] o_stim, o_busy, o_done, o_pass, o_err, o_ffv, o_ffvec;

    always #5 clk = ~clk;

    always_comb begin
        f_a = rand_mode ? rand_f : ((^a_stim) ^ (fault && (a_stim == 4'd5 || a_stim == 4'd11)));
        f_b = rand_mode ? rand_f : ((^b_stim) ^ (fault && (b_stim == 4'd5 || b_stim == 4'd11)));
        f_c = rand_mode ? rand_f : (^c_stim);
    end

    truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(20), .EXP_TABLE(16'h6996), .STOP_ON_FAIL(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_f(f_a), .stim(a_stim), .busy(a_busy),
        .done(a_done), .pass(a_pass), .err_count(a_err), .first_fail_valid(a_ffv),
        .first_fail_vec(a_ffvec));

    truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(20), .EXP_TABLE(16'h6996), .STOP_ON_FAIL(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_f(f_b), .stim(b_stim), .busy(b_busy),
        .done(b_done), .pass(b_pass), .err_count(b_err), .first_fail_valid(b_ffv),
        .first_fail_vec(b_ffvec));

    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(1), .EXP_TABLE(8'h96), .STOP_ON_FAIL(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .dut_f(f_c), .stim(c_stim), .busy(c_busy),
        .done(c_done), .pass(c_pass), .err_count(c_err), .first_fail_valid(c_ffv),
        .first_fail_vec(c_ffvec));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap(input int sel);
        case (sel)
            0: begin o_stim = 32'(a_stim); o_busy = 32'(a_busy); o_done = 32'(a_done); o_pass = 32'(a_pass);
                     o_err = 32'(a_err); o_ffv = 32'(a_ffv); o_ffvec = 32'(a_ffvec); end
            1: begin o_stim = 32'(b_stim); o_busy = 32'(b_busy); o_done = 32'(b_done); o_pass = 32'(b_pass);
                     o_err = 32'(b_err); o_ffv = 32'(b_ffv); o_ffvec = 32'(b_ffvec); end
            default: begin o_stim = 32'(c_stim); o_busy = 32'(c_busy); o_done = 32'(c_done); o_pass = 32'(c_pass);
                     o_err = 32'(c_err); o_ffv = 32'(c_ffv); o_ffvec = 32'(c_ffvec); end
        endcase
    endtask

    task automatic check_all(input string tag, input int sel, input logic [31:0] stim_e, input logic [31:0] busy_e,
                             input logic [31:0] done_e, input logic [31:0] pass_e, input logic [31:0] err_e,
                             input logic [31:0] ffv_e, input logic [31:0] ffvec_e);
        snap(sel);
        check({tag, ".stim"}, o_stim, stim_e);
        check({tag, ".busy"}, o_busy, busy_e);
        check({tag, ".done"}, o_done, done_e);
        check({tag, ".pass"}, o_pass, pass_e);
        check({tag, ".err"}, o_err, err_e);
        check({tag, ".ffv"}, o_ffv, ffv_e);
        check({tag, ".ffvec"}, o_ffvec, ffvec_e);
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic pulse(input int sel);
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
    endtask

    // Entered on a negedge where the sweep is already running; returns on the
    // first negedge where busy has dropped.
    task automatic measure(input string tag, input int sel, input int period, output int cycles);
        cycles = 0;
        snap(sel);
        while (o_busy[0] && cycles < 2000) begin
            if (cycles % period == 0) check({tag, ".stim_step"}, o_stim, 32'(cycles / period));
            else if (o_stim != 32'(cycles / period)) check({tag, ".stim_hold"}, o_stim, 32'(cycles / period));
            cycles++;
            @(negedge clk);
            snap(sel);
        end
        if (cycles >= 2000) check({tag, ".timeout"}, 32'(cycles), 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        fault = 1'b0; rand_mode = 1'b1; rand_f = 1'b0;

        // Reset with random start/dut_f
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_a = 1'($urandom); start_b = 1'($urandom); start_c = 1'($urandom); rand_f = 1'($urandom);
        end
        @(negedge clk);
        check_all("rst_a", 0, 0, 0, 0, 0, 0, 0, 0);
        check_all("rst_c", 2, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; rand_mode = 1'b0;
        @(negedge clk);
        check_all("idle_b", 1, 0, 0, 0, 0, 0, 0, 0);

        // Full passing sweep
        pulse(0);
        measure("full", 0, 20, cyc);
        check("full.len", 32'(cyc), 32'd320);
        check_all("full", 0, 0, 0, 1, 1, 0, 0, 0);

        // Start held high throughout: one sweep only
        @(negedge clk); start_a = 1'b1;
        @(negedge clk);
        measure("held", 0, 20, cyc);
        start_a = 1'b0;
        check("held.len", 32'(cyc), 32'd320);
        check_all("held", 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check_all("held_after", 0, 0, 0, 1, 1, 0, 0, 0);

        // Faulty block, vectors 5 and 11
        fault = 1'b1;
        pulse(0);
        measure("fault", 0, 20, cyc);
        check("fault.len", 32'(cyc), 32'd320);
        check_all("fault", 0, 0, 0, 1, 0, 2, 1, 5);

        // Restart from DONE with a correct block
        fault = 1'b0;
        pulse(0);
        check_all("restart", 0, 0, 1, 0, 0, 0, 0, 0);
        measure("restart", 0, 20, cyc);
        check("restart.len", 32'(cyc), 32'd320);
        check_all("restart_end", 0, 0, 0, 1, 1, 0, 0, 0);

        // STOP_ON_FAIL instance stops after vector 5
        fault = 1'b1;
        pulse(1);
        measure("stop", 1, 20, cyc);
        check("stop.len", 32'(cyc), 32'd120);
        check_all("stop", 1, 0, 0, 1, 0, 1, 1, 5);
        fault = 1'b0;

        // Reset mid-sweep at stim=7
        pulse(0);
        cyc = 0;
        while (a_stim != 4'd7 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst.reach7", 32'(a_stim), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        pulse(0);
        measure("post_rst", 0, 20, cyc);
        check("post_rst.len", 32'(cyc), 32'd320);
        check_all("post_rst", 0, 0, 0, 1, 1, 0, 0, 0);

        // N_IN=3, HOLD_CYCLES=1
        pulse(2);
        measure("small", 2, 1, cyc);
        check("small.len", 32'(cyc), 32'd8);
        check_all("small", 2, 0, 0, 1, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
